// File: rtl/ppg_pkg.sv
// Shared types and constants for the PPG outer-loop convergence controller.
package ppg_pkg;

   localparam int IW_DEF = 16;
   localparam int Q_DEF  = 15;

   // Q-format representation of 1.0
   localparam logic [31:0] ONE = 32'd1 << Q_DEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      EVAL   = 2'd3
   } state_t;

endpackage

// File: rtl/ppg_conv_check.sv
// Combinational convergence test: hit when max_dxj <= (max_xj * tol) >> Q.
module ppg_conv_check #(
   parameter int N = 32,
   parameter int Q = 15
) (
   input  logic [N-1:0] max_xj,
   input  logic [N-1:0] max_dxj,
   input  logic [N-1:0] tol,
   output logic         hit
);

   logic [2*N-1:0] prod_s;
   logic [N-1:0]   thr_s;

   assign prod_s = {{N{1'b0}}, max_xj} * {{N{1'b0}}, tol};
   // Threshold is the shifted product truncated back to the data width.
   assign thr_s  = N'(prod_s >> Q);
   assign hit    = (max_dxj <= thr_s);

endmodule

// File: rtl/ppg_converge_ctrl.sv
// Outer-loop controller: launches coordinate-descent sweeps until convergence or max_iter.
// Optional abort support is enabled with the PPG_CONV_ABORT_EN macro.
module ppg_converge_ctrl
   import ppg_pkg::*;
#(
   parameter int I  = 20,
   parameter int J  = 240,
   parameter int Q  = 15,
   parameter int N  = 32,
   parameter int IW = IW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [N-1:0]  xhat_init [0:J-1],
   input  logic [N-1:0]  r_init [0:I-1],
   input  logic [N-1:0]  max_xj_init,
   input  logic [N-1:0]  tol,
   input  logic [IW-1:0] max_iter,
   output logic          it_start,
   output logic [N-1:0]  it_xhat [0:J-1],
   output logic [N-1:0]  it_r [0:I-1],
   output logic [N-1:0]  it_max_xj,
   input  logic          it_done,
   input  logic [N-1:0]  it_r_out [0:I-1],
   input  logic [N-1:0]  it_max_xj_out,
   input  logic [N-1:0]  it_max_dxj_out,
   input  logic [N-1:0]  it_xhat_out [0:J-1],
   output logic [N-1:0]  xhat_final [0:J-1],
   output logic [IW-1:0] iter_count,
   output logic          converged,
   output logic          done
`ifdef PPG_CONV_ABORT_EN
   ,input  logic         abort
   ,output logic         aborted
`endif
);

   localparam logic [IW-1:0] ITER_ONE = IW'(1);

   state_t        state_q, state_d;
   logic [N-1:0]  xhat_q [0:J-1];
   logic [N-1:0]  r_q [0:I-1];
   logic [N-1:0]  max_xj_q;
   logic [N-1:0]  dxj_q;
   logic [IW-1:0] iter_q;
   logic          conv_q;
   logic          done_q;
   logic          it_start_q;
   logic          it_done_q;

   logic          rise_s;
   logic          hit_s;
   logic          limit_s;
   logic          abort_term_s;
   logic [IW-1:0] max_iter_eff_s;

   assign rise_s         = it_done & ~it_done_q;
   assign max_iter_eff_s = (max_iter == {IW{1'b0}}) ? ITER_ONE : max_iter;
   assign limit_s        = (iter_q >= max_iter_eff_s);

   ppg_conv_check #(.N(N), .Q(Q)) u_check (
      .max_xj  (max_xj_q),
      .max_dxj (dxj_q),
      .tol     (tol),
      .hit     (hit_s)
   );

`ifdef PPG_CONV_ABORT_EN
   logic abort_req_q;
   logic aborted_q;

   assign abort_term_s = abort_req_q | abort;
   assign aborted      = aborted_q;

   // Sticky abort request and the aborted status flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abort_req_q <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         if (state_q == EVAL) begin
            abort_req_q <= 1'b0;
         end else if (abort && (state_q != IDLE)) begin
            abort_req_q <= 1'b1;
         end
         if ((state_q == IDLE) && start) begin
            aborted_q <= 1'b0;
         end else if ((state_q == EVAL) && abort_term_s) begin
            aborted_q <= 1'b1;
         end
      end
   end
`else
   assign abort_term_s = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = LAUNCH;
            else       state_d = IDLE;
         end
         LAUNCH: state_d = WAIT;
         WAIT: begin
            if (rise_s) state_d = EVAL;
            else        state_d = WAIT;
         end
         EVAL: begin
            if (hit_s || limit_s || abort_term_s) state_d = IDLE;
            else                                  state_d = LAUNCH;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, holding registers, iteration count and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         max_xj_q   <= {N{1'b0}};
         dxj_q      <= {N{1'b0}};
         iter_q     <= {IW{1'b0}};
         conv_q     <= 1'b0;
         done_q     <= 1'b0;
         it_start_q <= 1'b0;
         it_done_q  <= 1'b0;
         for (int k = 0; k < J; k++) xhat_q[k] <= {N{1'b0}};
         for (int k = 0; k < I; k++) r_q[k] <= {N{1'b0}};
      end else begin
         state_q    <= state_d;
         it_done_q  <= it_done;
         it_start_q <= (state_d == LAUNCH);
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int k = 0; k < J; k++) xhat_q[k] <= xhat_init[k];
                  for (int k = 0; k < I; k++) r_q[k] <= r_init[k];
                  max_xj_q <= max_xj_init;
                  iter_q   <= {IW{1'b0}};
                  conv_q   <= 1'b0;
                  done_q   <= 1'b0;
               end
            end
            WAIT: begin
               if (rise_s) begin
                  for (int k = 0; k < J; k++) xhat_q[k] <= it_xhat_out[k];
                  for (int k = 0; k < I; k++) r_q[k] <= it_r_out[k];
                  max_xj_q <= it_max_xj_out;
                  dxj_q    <= it_max_dxj_out;
                  if (iter_q != {IW{1'b1}}) iter_q <= iter_q + ITER_ONE;
               end
            end
            EVAL: begin
               if (hit_s) begin
                  conv_q <= 1'b1;
                  done_q <= 1'b1;
               end else if (limit_s || abort_term_s) begin
                  conv_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign it_start   = it_start_q;
   assign it_xhat    = xhat_q;
   assign it_r       = r_q;
   assign it_max_xj  = max_xj_q;
   assign xhat_final = xhat_q;
   assign iter_count = iter_q;
   assign converged  = conv_q;
   assign done       = done_q;

endmodule

// File: tb/tb_ppg_converge_ctrl.sv
// Scoreboard bench for ppg_converge_ctrl with a behavioural sweep-block model.
module tb_ppg_converge_ctrl;
   import ppg_pkg::*;

   localparam int I = 20, J = 240, Q = 15, N = 32, IW = 16;

   logic          clk = 1'b0;
   logic          rst_n, start;
   logic [N-1:0]  xhat_init [0:J-1];
   logic [N-1:0]  r_init [0:I-1];
   logic [N-1:0]  max_xj_init, tol;
   logic [IW-1:0] max_iter;
   logic          it_start, it_done;
   logic [N-1:0]  it_xhat [0:J-1];
   logic [N-1:0]  it_r [0:I-1];
   logic [N-1:0]  it_max_xj, it_max_xj_out, it_max_dxj_out;
   logic [N-1:0]  it_r_out [0:I-1];
   logic [N-1:0]  it_xhat_out [0:J-1];
   logic [N-1:0]  xhat_final [0:J-1];
   logic [IW-1:0] iter_count;
   logic          converged, done;
`ifdef PPG_CONV_ABORT_EN
   logic          abort, aborted;
`endif

   ppg_converge_ctrl #(.I(I), .J(J), .Q(Q), .N(N), .IW(IW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .xhat_init(xhat_init), .r_init(r_init), .max_xj_init(max_xj_init),
      .tol(tol), .max_iter(max_iter),
      .it_start(it_start), .it_xhat(it_xhat), .it_r(it_r), .it_max_xj(it_max_xj),
      .it_done(it_done), .it_r_out(it_r_out), .it_max_xj_out(it_max_xj_out),
      .it_max_dxj_out(it_max_dxj_out), .it_xhat_out(it_xhat_out),
      .xhat_final(xhat_final), .iter_count(iter_count),
      .converged(converged), .done(done)
`ifdef PPG_CONV_ABORT_EN
      , .abort(abort), .aborted(aborted)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int xseed; int rseed; logic [31:0] mxj; logic [31:0] dxj; } sweep_t;
   typedef struct { int iters; bit conv; int xseed; bit ab; } exp_t;

   sweep_t plan_q[$];
   sweep_t sweep_q[$];
   exp_t   exp_q[$];
   int     checks = 0, errors = 0, pulses = 0, abort_at = 0;
   int     exp_xseed = 0, exp_rseed = 0;
   logic [31:0] exp_mxj = 32'd0;

   function automatic logic [31:0] word(int seed, int k);
      return (32'(seed) * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA6B) ^ 32'h0000_1234;
   endfunction

   function automatic logic [31:0] thr_of(logic [31:0] mxj, logic [31:0] t);
      logic [63:0] p;
      p = 64'(mxj) * 64'(t);
      return 32'(p / (64'd1 << Q));
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Sweep-block model: answers each it_start with the next planned result.
   initial begin : sweep_model
      int st, cnt, bad;
      sweep_t s;
      st = 0; cnt = 0;
      it_done = 1'b0; it_max_xj_out = '0; it_max_dxj_out = '0;
      for (int k = 0; k < J; k++) it_xhat_out[k] = '0;
      for (int k = 0; k < I; k++) it_r_out[k] = '0;
`ifdef PPG_CONV_ABORT_EN
      abort = 1'b0;
`endif
      forever begin
         @(negedge clk);
`ifdef PPG_CONV_ABORT_EN
         abort = 1'b0;
`endif
         if (!rst_n) begin
            st = 0; it_done = 1'b0;
         end else begin
            case (st)
               0: if (it_start) begin
                  pulses++;
                  bad = 0;
                  for (int k = 0; k < J; k++) if (it_xhat[k] !== word(exp_xseed, k)) bad++;
                  check("sweep_in_xhat", bad, 0);
                  bad = 0;
                  for (int k = 0; k < I; k++) if (it_r[k] !== word(exp_rseed, k)) bad++;
                  check("sweep_in_r", bad, 0);
                  check("sweep_in_max_xj", it_max_xj, exp_mxj);
                  st = 1;
               end
               1: begin
`ifdef PPG_CONV_ABORT_EN
                  if (pulses == abort_at) abort = 1'b1;
`endif
                  st = 2;
               end
               2: begin
                  it_done = 1'b0;
                  cnt = $urandom_range(0, 3);
                  st = 3;
               end
               3: if (cnt > 0) cnt--;
                  else begin
                     check("held_max_xj", it_max_xj, exp_mxj);
                     check("held_xhat_last", it_xhat[J-1], word(exp_xseed, J-1));
                     if (sweep_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sweep_extra actual=%0d required=%0d", pulses, pulses - 1);
                     end else begin
                        s = sweep_q.pop_front();
                        for (int k = 0; k < J; k++) it_xhat_out[k] = word(s.xseed, k);
                        for (int k = 0; k < I; k++) it_r_out[k] = word(s.rseed, k);
                        it_max_xj_out = s.mxj;
                        it_max_dxj_out = s.dxj;
                        exp_xseed = s.xseed; exp_rseed = s.rseed; exp_mxj = s.mxj;
                        it_done = 1'b1;
                     end
                     st = 0;
                  end
               default: st = 0;
            endcase
         end
      end
   end

   // Monitor: on each rising done, compare results against the scoreboard.
   initial begin : monitor
      bit prev;
      int bad;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done && !prev) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               check("iter_count", iter_count, e.iters);
               check("converged", converged, e.conv);
               check("it_start_pulses", pulses, e.iters);
               bad = 0;
               for (int k = 0; k < J; k++) if (xhat_final[k] !== word(e.xseed, k)) bad++;
               check("xhat_final", bad, 0);
`ifdef PPG_CONV_ABORT_EN
               check("aborted", aborted, e.ab);
`endif
            end
            pulses = 0;
         end
         prev = done;
      end
   end

   task automatic add_sweep(logic [31:0] mxj, logic [31:0] dxj);
      sweep_t s;
      s.xseed = $urandom_range(1, 1000000);
      s.rseed = $urandom_range(1, 1000000);
      s.mxj = mxj; s.dxj = dxj;
      plan_q.push_back(s);
   endtask

   task automatic launch(logic [31:0] t, logic [IW-1:0] mi);
      int xs, rs;
      xs = $urandom_range(1, 1000000);
      rs = $urandom_range(1, 1000000);
      @(negedge clk);
      for (int k = 0; k < J; k++) xhat_init[k] = word(xs, k);
      for (int k = 0; k < I; k++) r_init[k] = word(rs, k);
      max_xj_init = $urandom_range(1, 70000);
      exp_xseed = xs; exp_rseed = rs; exp_mxj = max_xj_init;
      tol = t; max_iter = mi;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_solve(logic [31:0] t, logic [IW-1:0] mi, int ab, bit start_in_wait);
      exp_t e;
      int lim, cyc;
      bit hit;
`ifndef PPG_CONV_ABORT_EN
      ab = 0;
`endif
      lim = (mi == '0) ? 1 : int'(mi);
      e.iters = 0; e.conv = 1'b0; e.ab = 1'b0; e.xseed = 0;
      for (int k = 1; k <= plan_q.size(); k++) begin
         hit = (plan_q[k-1].dxj <= thr_of(plan_q[k-1].mxj, t));
         sweep_q.push_back(plan_q[k-1]);
         e.iters = k;
         e.xseed = plan_q[k-1].xseed;
         if (hit) e.conv = 1'b1;
         if (ab == k) e.ab = 1'b1;
         if (hit || ab == k || k >= lim) break;
      end
      abort_at = ab;
      exp_q.push_back(e);
      launch(t, mi);
      if (start_in_wait) begin
         @(negedge clk);
         for (int k = 0; k < J; k++) xhat_init[k] = word(777, k);
         max_xj_init = 32'h0000_DEAD;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      cyc = 0;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=0 required=1");
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         sweep_q.delete(); exp_q.delete(); pulses = 0;
      end
      repeat (2) @(negedge clk);
      plan_q.delete();
   endtask

   initial begin
      int lim, ab;
      logic [31:0] t, mxj, thr;
      logic [IW-1:0] mi;
      rst_n = 1'b0; start = 1'b0; tol = '0; max_iter = '0; max_xj_init = '0;
      for (int k = 0; k < J; k++) xhat_init[k] = '0;
      for (int k = 0; k < I; k++) r_init[k] = '0;
      repeat (3) @(negedge clk);
      check("rst_it_start", it_start, 0);
      check("rst_done", done, 0);
      check("rst_converged", converged, 0);
      check("rst_iter_count", iter_count, 0);
      check("rst_it_max_xj", it_max_xj, 0);
      check("rst_xhat_final", xhat_final[J-1], 0);
      check("rst_it_r", it_r[0], 0);
      rst_n = 1'b1;

      add_sweep(32'd32768, 32'd100);
      run_solve(32'd328, 16'd5, 0, 1'b0);

      for (int k = 0; k < 5; k++) add_sweep(32'd32768, 32'd1000);
      run_solve(32'd328, 16'd5, 0, 1'b0);

      add_sweep(32'd32768, 32'd1000);
      run_solve(32'd328, 16'd0, 0, 1'b0);

      add_sweep(32'd0, 32'd0);
      run_solve(32'd328, 16'd3, 0, 1'b0);

      add_sweep(32'd0, 32'd1);
      run_solve(ONE, 16'd1, 0, 1'b0);

      add_sweep(32'd32768, 32'd1000);
      add_sweep(32'd32768, 32'd328);
      run_solve(32'd328, 16'd5, 0, 1'b1);

`ifdef PPG_CONV_ABORT_EN
      for (int k = 0; k < 3; k++) add_sweep(32'd32768, 32'd1000);
      run_solve(32'd328, 16'd10, 2, 1'b0);
`endif

      abort_at = 0;
      launch(32'd328, 16'd5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_it_start", it_start, 0);
      check("midrst_done", done, 0);
      check("midrst_converged", converged, 0);
      check("midrst_iter_count", iter_count, 0);
      check("midrst_it_max_xj", it_max_xj, 0);
      check("midrst_xhat_final", xhat_final[0], 0);
      check("midrst_it_r", it_r[I-1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      sweep_q.delete();
      pulses = 0;

      for (int n = 0; n < 25; n++) begin
         t  = ($urandom_range(0, 3) == 0) ? ONE : 32'($urandom_range(0, 2000));
         mi = 16'($urandom_range(0, 6));
         lim = (mi == '0) ? 1 : int'(mi);
         for (int k = 0; k < lim; k++) begin
            mxj = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 80000));
            thr = thr_of(mxj, t);
            if ($urandom_range(0, 3) == 0) add_sweep(mxj, 32'($urandom_range(0, int'(thr))));
            else                           add_sweep(mxj, thr + 32'd1 + 32'($urandom_range(0, 500)));
         end
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lim) : 0;
         run_solve(t, mi, ab, 1'b0);
      end

      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL missing_done actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
